alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU between NREQ requesters (e.g. EX stage and a multi-cycle helper).

---
 rtl/alu_share_arbiter_if.sv | 46 ++++
 rtl/alu_share_arbiter.sv | 176 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter_if
// Purpose  : Bundles the request, ALU-side and response signals of the
//            shared-ALU arbiter. The slave modport is the arbiter's view;
//            the master modport is the requester/ALU/consumer view.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int TAG_W = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [32*NREQ-1:0]    req_opa;
  logic [32*NREQ-1:0]    req_opb;
  logic [4*NREQ-1:0]     req_ctrl;
  logic [TAG_W*NREQ-1:0] req_tag;
  logic [31:0]           alu_a;
  logic [31:0]           alu_b;
  logic [3:0]            alu_ctrl;
  logic [31:0]           alu_result;
  logic                  alu_zero;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2:0]            rsp_id;
  logic [31:0]           rsp_data;
  logic                  rsp_zero;
  logic                  rsp_err;
  logic [TAG_W-1:0]      rsp_tag;

  modport slave (
    input  req_valid, req_opa, req_opb, req_ctrl, req_tag,
    input  alu_result, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_ctrl,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, rsp_tag
  );

  modport master (
    output req_valid, req_opa, req_opb, req_ctrl, req_tag,
    output alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_ctrl,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, rsp_tag
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Shares one combinational ALU between NREQ requesters. Grants one
//            request, drives the ALU for a single EXEC cycle, registers the
//            result and returns it with requester id and tag.
//            Define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest index
//            wins); default is round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int NREQ  = 2,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  alu_share_arbiter_if.slave bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_next;
  ptr_t             rr_ptr;
  ptr_t             grant_id;
  logic             grant_found;
  logic             can_accept;
  logic             accept;
  logic [NREQ-1:0]  ready_vec;

  ptr_t             lat_id;
  logic [31:0]      lat_opa;
  logic [31:0]      lat_opb;
  logic [3:0]       lat_ctrl;
  logic [TAG_W-1:0] lat_tag;
  logic             illegal_op;

  logic             resp_valid;
  logic [2:0]       resp_id;
  logic [31:0]      resp_data;
  logic             resp_zero;
  logic             resp_err;
  logic [TAG_W-1:0] resp_tag;

  // Round-robin pick: lowest valid index at/after rr_ptr, else lowest overall.
  // rr_ptr is held at 0 in fixed-priority builds, giving lowest-index-wins.
  always_comb begin
    logic found_hi;
    logic found_lo;
    ptr_t pick_hi;
    ptr_t pick_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        found_lo = 1'b1;
        pick_lo  = ptr_t'(i);
        if (i >= int'(rr_ptr)) begin
          found_hi = 1'b1;
          pick_hi  = ptr_t'(i);
        end
      end
    end
    grant_found = found_lo;
    grant_id    = found_hi ? pick_hi : pick_lo;
  end

  // A new request can be taken when idle, or while the current response drains.
  always_comb begin
    can_accept = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
    accept     = grant_found && can_accept;
    ready_vec  = '0;
    if (accept) begin
      ready_vec[grant_id] = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = accept ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU is driven only during EXEC so it never sees stale operands.
  always_comb begin
    bus.alu_a    = 32'd0;
    bus.alu_b    = 32'd0;
    bus.alu_ctrl = 4'b0000;
    if (state == EXEC) begin
      bus.alu_a    = lat_opa;
      bus.alu_b    = lat_opb;
      bus.alu_ctrl = lat_ctrl;
    end
  end

  assign illegal_op = (lat_ctrl == 4'd0) || (lat_ctrl > 4'd10);

  // Request capture, arbitration pointer and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      lat_id     <= '0;
      lat_opa    <= '0;
      lat_opb    <= '0;
      lat_ctrl   <= '0;
      lat_tag    <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_zero  <= 1'b0;
      resp_err   <= 1'b0;
      resp_tag   <= '0;
    end else begin
      if (accept) begin
        lat_id   <= grant_id;
        lat_opa  <= bus.req_opa[32*grant_id +: 32];
        lat_opb  <= bus.req_opb[32*grant_id +: 32];
        lat_ctrl <= bus.req_ctrl[4*grant_id +: 4];
        lat_tag  <= bus.req_tag[TAG_W*grant_id +: TAG_W];
`ifdef ALU_ARB_FIXED_PRIO_EN
        rr_ptr   <= '0;
`else
        rr_ptr   <= (grant_id == ptr_t'(NREQ - 1)) ? '0 : grant_id + 1'b1;
`endif
      end
      if (state == EXEC) begin
        resp_valid <= 1'b1;
        resp_id    <= 3'(lat_id);
        resp_tag   <= lat_tag;
        if (illegal_op) begin
          resp_data <= 32'd0;
          resp_zero <= 1'b1;
          resp_err  <= 1'b1;
        end else begin
          resp_data <= bus.alu_result;
          resp_zero <= bus.alu_zero;
          resp_err  <= 1'b0;
        end
      end else if ((state == RESP) && bus.rsp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.rsp_valid = resp_valid;
  assign bus.rsp_id    = resp_id;
  assign bus.rsp_data  = resp_data;
  assign bus.rsp_zero  = resp_zero;
  assign bus.rsp_err   = resp_err;
  assign bus.rsp_tag   = resp_tag;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Directed self-checking bench for alu_share_arbiter with a small
//            behavioural ALU attached. Honours ALU_ARB_FIXED_PRIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

  localparam int NREQ  = 2;
  localparam int TAG_W = 4;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  alu_share_arbiter_if #(.NREQ(NREQ), .TAG_W(TAG_W)) bus ();

  alu_share_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; illegal codes return a non-zero pattern.
  always_comb begin
    logic [31:0] r;
    r = 32'd0;
    case (bus.alu_ctrl)
      4'd1:    r = bus.alu_a + bus.alu_b;
      4'd2:    r = bus.alu_a - bus.alu_b;
      4'd3:    r = bus.alu_a & bus.alu_b;
      4'd4:    r = bus.alu_a | bus.alu_b;
      4'd5:    r = bus.alu_a ^ bus.alu_b;
      4'd6:    r = ~(bus.alu_a | bus.alu_b);
      4'd7:    r = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      4'd8:    r = bus.alu_a << bus.alu_b[4:0];
      4'd9:    r = bus.alu_a >> bus.alu_b[4:0];
      4'd10:   r = 32'($signed(bus.alu_a) >>> bus.alu_b[4:0]);
      default: r = 32'hDEAD_BEEF;
    endcase
    bus.alu_result = r;
    bus.alu_zero   = (r == 32'd0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] c,
                         input logic [TAG_W-1:0] t);
    bus.req_valid[i]            = v;
    bus.req_opa[32*i +: 32]     = a;
    bus.req_opb[32*i +: 32]     = b;
    bus.req_ctrl[4*i +: 4]      = c;
    bus.req_tag[TAG_W*i +: TAG_W] = t;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_id;
    int last_id;
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.req_valid  = '0;
    bus.req_opa    = '0;
    bus.req_opb    = '0;
    bus.req_ctrl   = '0;
    bus.req_tag    = '0;
    bus.rsp_ready  = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_alu_ctrl",  64'(bus.alu_ctrl),  64'd0);
    check("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
    check("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
    reset = 1'b0;

    // Single add 5+7 from req0
    set_req(0, 1'b1, 32'd5, 32'd7, 4'd1, 4'd3);
    #1;
    check("t1_req_ready", 64'(bus.req_ready), 64'b01);
    tick();
    bus.req_valid[0] = 1'b0;
    #1;
    check("t1_exec_alu_a",  64'(bus.alu_a), 64'd5);
    check("t1_exec_alu_b",  64'(bus.alu_b), 64'd7);
    check("t1_exec_ctrl",   64'(bus.alu_ctrl), 64'd1);
    check("t1_exec_rvalid", 64'(bus.rsp_valid), 64'd0);
    tick();
    check("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("t1_rsp_data",  64'(bus.rsp_data), 64'd12);
    check("t1_rsp_zero",  64'(bus.rsp_zero), 64'd0);
    check("t1_rsp_id",    64'(bus.rsp_id), 64'd0);
    check("t1_rsp_tag",   64'(bus.rsp_tag), 64'd3);
    check("t1_rsp_err",   64'(bus.rsp_err), 64'd0);
    check("t1_resp_ctrl", 64'(bus.alu_ctrl), 64'd0);
    tick();
    check("t1_drained", 64'(bus.rsp_valid), 64'd0);

    // Both requesters continuously, sub 3-3, back-to-back
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, 32'd3, 32'd3, 4'd2, 4'd5);
    set_req(1, 1'b1, 32'd3, 32'd3, 4'd2, 4'd9);
    #1;
    check("t2_req_ready", 64'(bus.req_ready), 64'b01);
    last_id = 0;
    for (int i = 0; i < 4; i++) begin
      exp_id = FIXED ? 0 : (i % 2);
      tick();
      check("t2_exec_rvalid", 64'(bus.rsp_valid), 64'd0);
      tick();
      check("t2_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("t2_rsp_id",    64'(bus.rsp_id), 64'(exp_id));
      check("t2_rsp_tag",   64'(bus.rsp_tag), (exp_id == 0) ? 64'd5 : 64'd9);
      check("t2_rsp_data",  64'(bus.rsp_data), 64'd0);
      check("t2_rsp_zero",  64'(bus.rsp_zero), 64'd1);
      last_id = exp_id;
    end

    // Consumer stall for 5 cycles
    bus.rsp_ready = 1'b0;
    #1;
    check("t3_stall_ready", 64'(bus.req_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("t3_hold_id",    64'(bus.rsp_id), 64'(last_id));
      check("t3_hold_tag",   64'(bus.rsp_tag), (last_id == 0) ? 64'd5 : 64'd9);
      check("t3_hold_zero",  64'(bus.rsp_zero), 64'd1);
      check("t3_hold_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("t3_release_ready", 64'(bus.req_ready), 64'b01);
    tick();
    check("t3_exec_rvalid", 64'(bus.rsp_valid), 64'd0);
    tick();
    check("t3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("t3_rsp_id",    64'(bus.rsp_id), 64'd0);
    bus.req_valid = '0;
    tick();
    check("t3_idle", 64'(bus.rsp_valid), 64'd0);

    // Illegal op code from req1
    set_req(1, 1'b1, 32'd10, 32'd20, 4'hF, 4'd7);
    #1;
    check("t4_idle_ctrl",  64'(bus.alu_ctrl), 64'd0);
    check("t4_req_ready",  64'(bus.req_ready), 64'b10);
    tick();
    bus.req_valid = '0;
    #1;
    check("t4_exec_ctrl",  64'(bus.alu_ctrl), 64'hF);
    tick();
    check("t4_rsp_valid",  64'(bus.rsp_valid), 64'd1);
    check("t4_rsp_err",    64'(bus.rsp_err), 64'd1);
    check("t4_rsp_data",   64'(bus.rsp_data), 64'd0);
    check("t4_rsp_zero",   64'(bus.rsp_zero), 64'd1);
    check("t4_rsp_id",     64'(bus.rsp_id), 64'd1);
    check("t4_rsp_tag",    64'(bus.rsp_tag), 64'd7);
    check("t4_resp_ctrl",  64'(bus.alu_ctrl), 64'd0);
    tick();
    check("t4_drained", 64'(bus.rsp_valid), 64'd0);

    // Reset during EXEC discards the transaction and clears the pointer
    set_req(0, 1'b1, 32'd1, 32'd1, 4'd1, 4'd2);
    tick();
    bus.req_valid = '0;
    #1;
    check("t5_exec_ctrl", 64'(bus.alu_ctrl), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("t5_alu_a",     64'(bus.alu_a), 64'd0);
    check("t5_alu_ctrl",  64'(bus.alu_ctrl), 64'd0);
    check("t5_rsp_tag",   64'(bus.rsp_tag), 64'd0);
    check("t5_rsp_err",   64'(bus.rsp_err), 64'd0);
    repeat (2) begin
      tick();
      check("t5_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    set_req(0, 1'b1, 32'd1, 32'd1, 4'd1, 4'd2);
    set_req(1, 1'b1, 32'd4, 32'd4, 4'd1, 4'd6);
    #1;
    check("t5_next_grant", 64'(bus.req_ready), 64'b01);
    tick();
    bus.req_valid = '0;
    tick();
    check("t5_rsp_valid2", 64'(bus.rsp_valid), 64'd1);
    check("t5_rsp_id2",    64'(bus.rsp_id), 64'd0);
    check("t5_rsp_data2",  64'(bus.rsp_data), 64'd2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
